// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path: scan states, BCD width
// and the default display geometry used by the decoder and the top level.
package seg_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned DEF_NUM_DIGITS   = 5;
    localparam int unsigned DEF_CLK_DIV      = 1000;
    localparam int unsigned DEF_BLANK_CYCLES = 16;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle of the scan controller: frame load, enable and the
// decoder/digit-select outputs.
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = seg_pkg::DEF_NUM_DIGITS
);

    logic                                   en;
    logic                                   load;
    logic [seg_pkg::BCD_W*NUM_DIGITS-1:0]   digits;
    logic [seg_pkg::BCD_W-1:0]              digit_code;
    logic [NUM_DIGITS-1:0]                  SEG_SEL;
    logic                                   frame_done;

    modport master (
        output en, load, digits,
        input  digit_code, SEG_SEL, frame_done
    );

    modport slave (
        input  en, load, digits,
        output digit_code, SEG_SEL, frame_done
    );

endinterface

// File: rtl/seg_slot_timer.sv
// Slot counter for one digit slot; flags the last blank cycle, the
// second-to-last slot cycle and the last slot cycle.
module seg_slot_timer #(
    parameter int unsigned CLK_DIV      = seg_pkg::DEF_CLK_DIV,
    parameter int unsigned BLANK_CYCLES = seg_pkg::DEF_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic blank_end_c,
    output logic slot_pre_end_c,
    output logic slot_end_c
);

    localparam int unsigned CNT_W      = $clog2(CLK_DIV);
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;

    logic [CNT_W-1:0] cnt;

    // Count cycles inside a slot; cleared while idle and at each slot end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign blank_end_c    = (BLANK_CYCLES != 0) && (cnt == CNT_W'(BLANK_LAST));
    assign slot_pre_end_c = (cnt == CNT_W'(CLK_DIV - 2));
    assign slot_end_c     = (cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl import seg_pkg::*; #(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRAME_W = BCD_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e           state;
    scan_state_e           state_d;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_d;
    logic [FRAME_W-1:0]    shadow;
    logic [FRAME_W-1:0]    disp;
    logic [FRAME_W-1:0]    disp_d;
    logic                  blank_end_c;
    logic                  slot_pre_end_c;
    logic                  slot_end_c;
    logic                  timer_clr_c;
    logic                  slot_adv_c;
    logic                  boundary_c;
    logic                  show_c;
    logic [BCD_W-1:0]      code_d;
    logic [NUM_DIGITS-1:0] sel_d;
    logic                  done_d;
    logic [BCD_W-1:0]      digit_code_q;
    logic [NUM_DIGITS-1:0] seg_sel_q;
    logic                  frame_done_q;

    assign timer_clr_c = (state == SCAN_IDLE) || slot_end_c || !bus.en;

    seg_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (timer_clr_c),
        .blank_end_c    (blank_end_c),
        .slot_pre_end_c (slot_pre_end_c),
        .slot_end_c     (slot_end_c)
    );

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next scan state; dropping the enable always wins.
    always_comb begin
        state_d = state;
        case (state)
            SCAN_IDLE:  if (bus.en) state_d = (BLANK_CYCLES == 0) ? SCAN_DRIVE : SCAN_BLANK;
            SCAN_BLANK: if (blank_end_c) state_d = SCAN_DRIVE;
            SCAN_DRIVE: if (slot_end_c) state_d = (BLANK_CYCLES == 0) ? SCAN_DRIVE : SCAN_BLANK;
            default:    state_d = SCAN_IDLE;
        endcase
        if (!bus.en) state_d = SCAN_IDLE;
    end

    // Next digit index and display frame; the frame swaps only at a boundary.
    always_comb begin
        slot_adv_c = (state == SCAN_DRIVE) && slot_end_c;
        boundary_c = bus.en && ((state == SCAN_IDLE) || (slot_adv_c && (idx == IDX_LAST)));
        idx_d      = idx;
        disp_d     = disp;
        if (!bus.en || (state == SCAN_IDLE)) begin
            idx_d = '0;
        end else if (slot_adv_c) begin
            idx_d = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
        if (boundary_c) begin
            disp_d = bus.load ? bus.digits : shadow;
        end
    end

    // Output values for the coming cycle, registered below.
    always_comb begin
        sel_d  = '0;
        code_d = disp_d[BCD_W*int'(idx_d) +: BCD_W];
        done_d = bus.en && (state != SCAN_IDLE) && (idx == IDX_LAST) && slot_pre_end_c;
`ifdef SEG_SCAN_LZB_EN
        show_c = (idx_d == '0) || ((disp_d >> (BCD_W * int'(idx_d))) != '0);
`else
        show_c = 1'b1;
`endif
        if ((state_d == SCAN_DRIVE) && show_c) begin
            sel_d = NUM_DIGITS'(1) << idx_d;
        end
    end

    // Index, shadow and display frame registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            shadow <= '0;
            disp   <= '0;
        end else begin
            idx  <= idx_d;
            disp <= disp_d;
            if (bus.load) begin
                shadow <= bus.digits;
            end
        end
    end

    // Registered outputs to the decoder and digit drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_code_q <= '0;
            seg_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            digit_code_q <= code_d;
            seg_sel_q    <= sel_d;
            frame_done_q <= done_d;
        end
    end

    assign bus.digit_code = digit_code_q;
    assign bus.SEG_SEL    = seg_sel_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl against a cycle-position
// reference model (slot/frame position derived from cycles since scan start).
module tb_seg_scan_ctrl;

    localparam int unsigned N     = 5;
    localparam int unsigned CD    = 8;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = N * CD;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: active scan, cycles since scan start, frame shown.
    bit        m_active;
    int        m_t;
    bit [19:0] m_frame;
    bit [19:0] m_shadow;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cur_idx();
        return m_active ? (m_t / CD) % N : 0;
    endfunction

    function automatic int cur_pos();
        return m_active ? m_t % CD : 0;
    endfunction

    function automatic logic [31:0] exp_sel();
        int  i;
        bit  show;
        i    = cur_idx();
        show = 1'b1;
`ifdef SEG_SCAN_LZB_EN
        show = (i == 0) || ((m_frame >> (4 * i)) != 20'h0);
`endif
        if (!m_active || (cur_pos() < BC) || !show) return 32'h0;
        return 32'(1) << i;
    endfunction

    function automatic logic [31:0] exp_code();
        return 32'(m_frame[4*cur_idx() +: 4]);
    endfunction

    function automatic logic [31:0] exp_done();
        return (m_active && ((m_t % FRAME) == FRAME - 1)) ? 32'h1 : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!bus.en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
            m_frame  = bus.load ? bus.digits : m_shadow;
        end else begin
            m_t++;
            if ((m_t % FRAME) == 0) m_frame = bus.load ? bus.digits : m_shadow;
        end
        if (bus.load) m_shadow = bus.digits;
    endtask

    task automatic check_outputs();
        chk("seg_sel",    32'(bus.SEG_SEL),    exp_sel());
        chk("digit_code", 32'(bus.digit_code), exp_code());
        chk("frame_done", 32'(bus.frame_done), exp_done());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_slot(input string tag, input int ti, input int tp);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_active && (cur_idx() == ti) && (cur_pos() == tp)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(found), 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel"},  32'(bus.SEG_SEL),    32'h0);
        chk({tag, "_code"}, 32'(bus.digit_code), 32'h0);
        chk({tag, "_done"}, 32'(bus.frame_done), 32'h0);
    endtask

    initial begin
        m_active   = 1'b0;
        m_t        = 0;
        m_frame    = '0;
        m_shadow   = '0;
        rst_n      = 1'b0;
        bus.en     = 1'b1;
        bus.load   = 1'b1;
        bus.digits = 20'h43210;
        #3;
        check_reset_outputs("reset");

        // Scan starts with the loaded frame 0x43210 (bypass on entry).
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.load = 1'b0;
        run(2 * FRAME);

        // Load mid-frame: current frame keeps old digits, next frame shows 9s.
        wait_slot("wait_idx2", 2, 4);
        bus.load   = 1'b1;
        bus.digits = 20'h99999;
        step();
        bus.load = 1'b0;
        wait_slot("wait_next_frame", 0, 4);
        chk("frame_of_nines", 32'(bus.digit_code), 32'h9);
        run(FRAME);

        // Load in the frame_done cycle takes effect immediately (bypass).
        wait_slot("wait_boundary", N - 1, CD - 1);
        chk("boundary_pulse", 32'(bus.frame_done), 32'h1);
        bus.load   = 1'b1;
        bus.digits = 20'h12345;
        step();
        bus.load = 1'b0;
        chk("bypass_code", 32'(bus.digit_code), 32'h5);
        run(FRAME);

        // Drop enable at index 3, then restart from index 0.
        wait_slot("wait_idx3", 3, 4);
        bus.en = 1'b0;
        step();
        chk("en_drop_sel", 32'(bus.SEG_SEL), 32'h0);
        run(12);
        bus.en = 1'b1;
        run(FRAME + 10);

        // Asynchronous reset mid-DRIVE clears outputs at once; restart with disp=0.
        wait_slot("wait_drive", 1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_active = 1'b0;
        m_t      = 0;
        m_frame  = '0;
        m_shadow = '0;
        @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        run(FRAME + 5);

        // Frame with leading zeros and an embedded zero.
        bus.load   = 1'b1;
        bus.digits = 20'h00305;
        step();
        bus.load = 1'b0;
        run(2 * FRAME + 10);

        // Randomized loads (including codes 10-15) and enable drops.
        for (int i = 0; i < 500; i++) begin
            bus.load   = ($urandom_range(0, 15) == 0);
            bus.digits = 20'($urandom);
            bus.en     = ($urandom_range(0, 79) != 0);
            step();
        end
        bus.load = 1'b0;
        bus.en   = 1'b1;
        run(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
